// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction-fetch front end: entry record,
// default widths, PC step and the alignment mask used on redirect targets.
package fetch_pkg;

    localparam int unsigned FETCH_PC_W    = 64;
    localparam int unsigned FETCH_INSTR_W = 32;
    localparam int unsigned PC_STEP       = FETCH_INSTR_W / 8;
    localparam int unsigned FETCH_MASK_W  = 128;

    typedef struct packed {
        logic [FETCH_PC_W-1:0]    pc;
        logic [FETCH_INSTR_W-1:0] instr;
    } fetch_entry_t;

    // Mask with the byte-offset bits of an instruction-aligned address cleared.
    function automatic logic [FETCH_MASK_W-1:0] align_mask(input int unsigned step_bytes);
        logic [FETCH_MASK_W-1:0] low_s;
        low_s = FETCH_MASK_W'(step_bytes) - FETCH_MASK_W'(1);
        return ~low_s;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with push, pop and flush; flush beats push.
// Pointers wrap modulo DEPTH and the occupancy counter separates full from empty.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter type         entry_t = fetch_entry_t,
    parameter int unsigned DEPTH   = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  entry_t                   push_data,
    input  logic                     pop,
    output entry_t                   head,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    entry_t             mem_q [DEPTH];
    entry_t             mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               pop_ok_s;
    logic               push_ok_s;

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;
        pop_ok_s  = pop & (cnt_q != CNT_W'(0));
        push_ok_s = push & ((cnt_q < CNT_W'(DEPTH)) | pop_ok_s);
        if (flush) begin
            wr_ptr_d = PTR_W'(0);
            rd_ptr_d = PTR_W'(0);
            cnt_d    = CNT_W'(0);
        end else begin
            if (push_ok_s) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_ok_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   cnt_d = cnt_q + CNT_W'(1);
                2'b01:   cnt_d = cnt_q - CNT_W'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Control state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= PTR_W'(0);
            rd_ptr_q <= PTR_W'(0);
            cnt_q    <= CNT_W'(0);
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Entry storage; contents are only meaningful below the occupancy count.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head  = mem_q[rd_ptr_q];
    assign valid = (cnt_q != CNT_W'(0));
    assign count = cnt_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC register, push/redirect control and entry FIFO.
// Optional FETCH_MISALIGN_CHK_EN adds a sticky fetch_fault for misaligned redirects.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned     PC_W     = FETCH_PC_W,
    parameter int unsigned     INSTR_W  = FETCH_INSTR_W,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     fetch_en,
    input  logic                     redirect_valid,
    input  logic [PC_W-1:0]          redirect_target,
    output logic [PC_W-1:0]          imem_addr,
    input  logic [INSTR_W-1:0]       imem_rdata,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PC_W-1:0]          out_pc,
    output logic [INSTR_W-1:0]       out_instr,
`ifdef FETCH_MISALIGN_CHK_EN
    output logic                     fetch_fault,
`endif
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam logic [PC_W-1:0] STEP = PC_W'(INSTR_W / 8);

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] pc_mask_s;
    logic            pop_s;
    logic            push_s;
    logic            has_room_s;
    logic            blocked_s;
    entry_t          push_data_s;
    entry_t          head_s;

`ifdef FETCH_MISALIGN_CHK_EN
    logic fault_q, fault_d;
    logic misalign_s;
`endif

    // PC update, push decision and fault tracking; redirect outranks fetch.
    always_comb begin
        pc_mask_s  = PC_W'(align_mask(INSTR_W / 8));
        pop_s      = out_valid & out_ready;
        has_room_s = (fifo_count < ($clog2(DEPTH) + 1)'(DEPTH)) | pop_s;
        push_s     = 1'b0;
        pc_d       = pc_q;
`ifdef FETCH_MISALIGN_CHK_EN
        fault_d    = fault_q;
        misalign_s = |(redirect_target & ~pc_mask_s);
        blocked_s  = fault_q;
`else
        blocked_s  = 1'b0;
`endif
        if (redirect_valid) begin
`ifdef FETCH_MISALIGN_CHK_EN
            if (misalign_s) begin
                fault_d = 1'b1;
                pc_d    = pc_q;
            end else begin
                pc_d = redirect_target;
            end
`else
            pc_d = redirect_target & pc_mask_s;
`endif
        end else if (fetch_en & has_room_s & ~blocked_s) begin
            push_s = 1'b1;
            pc_d   = pc_q + STEP;
        end else begin
            pc_d = pc_q;
        end
        push_data_s.pc    = pc_q;
        push_data_s.instr = imem_rdata;
    end

    // PC and fault flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_PC;
`ifdef FETCH_MISALIGN_CHK_EN
            fault_q <= 1'b0;
`endif
        end else begin
            pc_q <= pc_d;
`ifdef FETCH_MISALIGN_CHK_EN
            fault_q <= fault_d;
`endif
        end
    end

    fetch_fifo #(
        .entry_t (entry_t),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (push_s),
        .push_data (push_data_s),
        .pop       (pop_s),
        .head      (head_s),
        .valid     (out_valid),
        .count     (fifo_count)
    );

    assign imem_addr = pc_q;
    assign out_pc    = head_s.pc;
    assign out_instr = head_s.instr;
`ifdef FETCH_MISALIGN_CHK_EN
    assign fetch_fault = fault_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Table-driven directed bench for fetch_unit (DEPTH=4, 64-bit PC, 32-bit instr),
// plus a hand-written misaligned-redirect sequence for either build.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_en;
    logic        redirect_valid;
    logic [63:0] redirect_target;
    logic [63:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
    logic [2:0]  fifo_count;
`ifdef FETCH_MISALIGN_CHK_EN
    logic        fetch_fault;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Instruction memory: data derived from address.
    assign imem_rdata = imem_addr[31:0] ^ 32'hC0DE_0000;

    fetch_unit #(.PC_W(64), .INSTR_W(32), .DEPTH(4), .RESET_PC(64'h0)) dut (
        .clk             (clk),
        .reset           (reset),
        .fetch_en        (fetch_en),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem_addr       (imem_addr),
        .imem_rdata      (imem_rdata),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_pc          (out_pc),
        .out_instr       (out_instr),
`ifdef FETCH_MISALIGN_CHK_EN
        .fetch_fault     (fetch_fault),
`endif
        .fifo_count      (fifo_count)
    );

    typedef struct {
        logic        rst;
        logic        fe;
        logic        rdy;
        logic        rv;
        logic [63:0] tgt;
        logic        exp_v;
        logic [63:0] exp_pc;
        logic [2:0]  exp_cnt;
        logic [63:0] exp_addr;
    } row_t;

    row_t rows[$];

    function automatic logic [31:0] instr_of(input logic [63:0] pc);
        return pc[31:0] ^ 32'hC0DE_0000;
    endfunction

    function automatic void add(input logic rst, input logic fe, input logic rdy, input logic rv,
                                input logic [63:0] tgt, input logic exp_v, input logic [63:0] exp_pc,
                                input logic [2:0] exp_cnt, input logic [63:0] exp_addr);
        row_t r;
        r.rst = rst; r.fe = fe; r.rdy = rdy; r.rv = rv; r.tgt = tgt;
        r.exp_v = exp_v; r.exp_pc = exp_pc; r.exp_cnt = exp_cnt; r.exp_addr = exp_addr;
        rows.push_back(r);
    endfunction

    task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic fe, input logic rdy, input logic rv, input logic [63:0] tgt);
        reset           = rst;
        fetch_en        = fe;
        out_ready       = rdy;
        redirect_valid  = rv;
        redirect_target = tgt;
    endtask

    initial begin
        // Row: inputs applied this cycle | expected state observed before applying them.
        //   rst fe rdy rv target              v  out_pc               cnt   imem_addr
        add(0, 1, 1, 0, 64'h0,                0, 64'h0,                3'd0, 64'h0);   // free run
        add(0, 1, 1, 0, 64'h0,                1, 64'h0,                3'd1, 64'h4);
        add(0, 1, 1, 0, 64'h0,                1, 64'h4,                3'd1, 64'h8);
        add(0, 0, 1, 0, 64'h0,                1, 64'h8,                3'd1, 64'hC);
        add(0, 1, 1, 0, 64'h0,                0, 64'h0,                3'd0, 64'hC);   // fetch_en=0 held pc
        add(1, 1, 1, 0, 64'h0,                1, 64'hC,                3'd1, 64'h10);  // reset mid-stream
        add(0, 1, 0, 0, 64'h0,                0, 64'h0,                3'd0, 64'h0);   // stall fill
        add(0, 1, 0, 0, 64'h0,                1, 64'h0,                3'd1, 64'h4);
        add(0, 1, 0, 0, 64'h0,                1, 64'h0,                3'd2, 64'h8);
        add(0, 1, 0, 0, 64'h0,                1, 64'h0,                3'd3, 64'hC);
        add(0, 1, 0, 0, 64'h0,                1, 64'h0,                3'd4, 64'h10);  // full, pc holds
        add(0, 1, 0, 0, 64'h0,                1, 64'h0,                3'd4, 64'h10);
        add(0, 1, 1, 0, 64'h0,                1, 64'h0,                3'd4, 64'h10);  // full + pop + push
        add(0, 0, 1, 0, 64'h0,                1, 64'h4,                3'd4, 64'h14);
        add(0, 1, 1, 1, 64'h100,              1, 64'h8,                3'd3, 64'h14);  // redirect w/ pop
        add(0, 1, 1, 0, 64'h0,                0, 64'h0,                3'd0, 64'h100);
        add(0, 1, 0, 1, 64'h200,              1, 64'h100,              3'd1, 64'h104); // back-to-back
        add(0, 1, 0, 1, 64'h300,              0, 64'h0,                3'd0, 64'h200);
        add(0, 1, 1, 0, 64'h0,                0, 64'h0,                3'd0, 64'h300);
        add(0, 0, 1, 0, 64'h0,                1, 64'h300,              3'd1, 64'h304);
        add(0, 1, 1, 1, 64'hFFFF_FFFF_FFFF_FFF8, 0, 64'h0,             3'd0, 64'h304); // near top
        add(0, 1, 1, 0, 64'h0,                0, 64'h0,                3'd0, 64'hFFFF_FFFF_FFFF_FFF8);
        add(0, 1, 1, 0, 64'h0,                1, 64'hFFFF_FFFF_FFFF_FFF8, 3'd1, 64'hFFFF_FFFF_FFFF_FFFC);
        add(0, 1, 1, 0, 64'h0,                1, 64'hFFFF_FFFF_FFFF_FFFC, 3'd1, 64'h0); // wrapped
        add(0, 1, 0, 0, 64'h0,                1, 64'h0,                3'd1, 64'h4);
        add(1, 0, 0, 0, 64'h0,                1, 64'h0,                3'd2, 64'h8);   // reset w/ 2 queued
        add(0, 0, 0, 0, 64'h0,                0, 64'h0,                3'd0, 64'h0);
        add(0, 0, 0, 0, 64'h0,                0, 64'h0,                3'd0, 64'h0);

        drive(1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
        repeat (2) @(posedge clk);

        for (int i = 0; i < rows.size(); i++) begin
            @(negedge clk);
            chk("out_valid",  i, 64'(out_valid),  64'(rows[i].exp_v));
            chk("fifo_count", i, 64'(fifo_count), 64'(rows[i].exp_cnt));
            chk("imem_addr",  i, imem_addr,       rows[i].exp_addr);
            if (rows[i].exp_v) begin
                chk("out_pc",    i, out_pc,           rows[i].exp_pc);
                chk("out_instr", i, 64'(out_instr),   64'(instr_of(rows[i].exp_pc)));
            end
            drive(rows[i].rst, rows[i].fe, rows[i].rdy, rows[i].rv, rows[i].tgt);
        end

        // Misaligned redirect to 0x102 from an empty FIFO with pc=0.
        @(negedge clk);
`ifdef FETCH_MISALIGN_CHK_EN
        chk("fault_pre", 100, 64'(fetch_fault), 64'h0);
`endif
        drive(1'b0, 1'b1, 1'b1, 1'b1, 64'h102);
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 64'h0);
`ifdef FETCH_MISALIGN_CHK_EN
        chk("fault_set",  101, 64'(fetch_fault), 64'h1);
        chk("mis_addr",   101, imem_addr,        64'h0);
        @(negedge clk);
        chk("mis_valid",  102, 64'(out_valid),   64'h0);
        chk("mis_count",  102, 64'(fifo_count),  64'h0);
        @(negedge clk);
        chk("mis_block",  103, 64'(fifo_count),  64'h0);
        chk("fault_hold", 103, 64'(fetch_fault), 64'h1);
`else
        chk("mis_addr",   101, imem_addr,        64'h100);
        chk("mis_count",  101, 64'(fifo_count),  64'h0);
        @(negedge clk);
        chk("mis_valid",  102, 64'(out_valid),   64'h1);
        chk("mis_pc",     102, out_pc,           64'h100);
        @(negedge clk);
        chk("mis_pc2",    103, out_pc,           64'h104);
`endif
        drive(1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 64'h0);
        chk("rst_count", 104, 64'(fifo_count), 64'h0);
        chk("rst_addr",  104, imem_addr,       64'h0);
`ifdef FETCH_MISALIGN_CHK_EN
        chk("fault_clr", 104, 64'(fetch_fault), 64'h0);
`endif
        @(negedge clk);
        chk("resume_v",  105, 64'(out_valid), 64'h1);
        chk("resume_pc", 105, out_pc,         64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
